speed_selector: RTL and testbench



---
 rtl/speed_selector.sv | 106 ++++++++++
 tb/tb_speed_selector.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/speed_selector.sv
// Pushbutton front end for the PWM generator: synchronises and debounces up/down/stop,
// holds a saturating target speed and ramps the output speed one step at a time toward it.
module speed_selector #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int RAMP_CYCLES     = 32
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_stop,
    output logic [2:0] speed,
    output logic [2:0] target,
    output logic       busy
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(RAMP_CYCLES - 1);
    localparam int UP = 0;
    localparam int DN = 1;
    localparam int ST = 2;

    typedef enum logic {IDLE, RAMP} ramp_state_e;
    ramp_state_e ramp_state;

    logic [2:0]    btn_raw;
    logic [2:0]    sync1_q, sync2_q;
    logic [2:0]    stable_q, stable_d, stable_dly_q;
    logic [2:0]    press;
    logic [DW-1:0] db_cnt_q [3];
    logic [DW-1:0] db_cnt_d [3];
    logic [2:0]    speed_q, speed_d, target_q, target_d;
    logic [TW-1:0] tick_q, tick_d;

    assign btn_raw = {btn_stop, btn_down, btn_up};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
            speed_q      <= '0;
            target_q     <= '0;
            tick_q       <= '0;
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
            speed_q      <= speed_d;
            target_q     <= target_d;
            tick_q       <= tick_d;
        end
    end

    // Any sample that agrees with the debounced level restarts that button's count.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) stable_d[i] = sync2_q[i];
                else                        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    assign press      = stable_q & ~stable_dly_q;
    assign ramp_state = (speed_q == target_q) ? IDLE : RAMP;

    // The step direction uses the target written on the same edge, so speed cannot overshoot.
    always_comb begin
        target_d = target_q;
        speed_d  = speed_q;
        tick_d   = tick_q;
        if (press[ST]) begin
            target_d = '0;
            speed_d  = '0;
            tick_d   = '0;
        end else begin
            if (press[UP] && !press[DN] && target_q != 3'd7)
                target_d = target_q + 3'd1;
            else if (press[DN] && !press[UP] && target_q != 3'd0)
                target_d = target_q - 3'd1;

            if (ramp_state == IDLE || target_d == speed_q) begin
                tick_d = '0;
            end else if (tick_q == TICK_LAST) begin
                tick_d  = '0;
                speed_d = (target_d > speed_q) ? speed_q + 3'd1 : speed_q - 3'd1;
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end
    end

    assign speed  = speed_q;
    assign target = target_q;
    assign busy   = (ramp_state == RAMP);

endmodule

// File: tb/tb_speed_selector.sv
// Bench for speed_selector: directed scenarios plus random button activity, every cycle
// compared against a cycle-level behavioural model of the button/target/ramp rules.
module tb_speed_selector;

    localparam int DB = 4;
    localparam int RC = 8;

    logic       clock    = 1'b0;
    logic       reset_n  = 1'b0;
    logic       btn_up   = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_stop = 1'b0;
    logic [2:0] speed;
    logic [2:0] target;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Model state: synchroniser, debounced level, its delayed copy, run length per button.
    int m_s1[3], m_s2[3], m_stab[3], m_dly[3], m_run[3];
    int m_t, m_s, m_k;

    always #5 clock = ~clock;

    speed_selector #(
        .DEBOUNCE_CYCLES (DB),
        .RAMP_CYCLES     (RC)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_stop (btn_stop),
        .speed    (speed),
        .target   (target),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_stab[i] = 0; m_dly[i] = 0; m_run[i] = 0;
        end
        m_t = 0; m_s = 0; m_k = 0;
    endtask

    task automatic model_edge(input bit u, input bit d, input bit st);
        int raw[3];
        int p[3];
        int nt;
        raw[0] = u; raw[1] = d; raw[2] = st;
        for (int i = 0; i < 3; i++) p[i] = (m_stab[i] == 1 && m_dly[i] == 0) ? 1 : 0;
        if (p[2] != 0) begin
            m_t = 0; m_s = 0; m_k = 0;
        end else begin
            nt = m_t;
            if (p[0] != 0 && p[1] == 0)      nt = (m_t < 7) ? m_t + 1 : 7;
            else if (p[1] != 0 && p[0] == 0) nt = (m_t > 0) ? m_t - 1 : 0;
            if (m_t == m_s || nt == m_s) begin
                m_k = 0;
            end else if (m_k == RC - 1) begin
                m_s = (nt > m_s) ? m_s + 1 : m_s - 1;
                m_k = 0;
            end else begin
                m_k = m_k + 1;
            end
            m_t = nt;
        end
        for (int i = 0; i < 3; i++) begin
            m_dly[i] = m_stab[i];
            if (m_s2[i] != m_stab[i]) begin
                if (m_run[i] == DB - 1) begin
                    m_stab[i] = m_s2[i];
                    m_run[i]  = 0;
                end else begin
                    m_run[i] = m_run[i] + 1;
                end
            end else begin
                m_run[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = raw[i];
        end
    endtask

    task automatic check_model();
        check("speed", {5'b0, speed}, 8'(m_s));
        check("target", {5'b0, target}, 8'(m_t));
        check("busy", {7'b0, busy}, (m_s != m_t) ? 8'd1 : 8'd0);
    endtask

    task automatic step(input bit u, input bit d, input bit st);
        btn_up = u; btn_down = d; btn_stop = st;
        @(posedge clock);
        model_edge(u, d, st);
        #1;
        check_model();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_btn(input bit u, input bit d, input bit st);
        repeat (DB + 2) step(u, d, st);
        repeat (DB + 2) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (speed != target && n < budget) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        check("wait_idle_done", {7'b0, (speed == target)}, 8'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] prev_speed;
        int         n;

        // Power-up reset
        model_reset();
        #12;
        check("rst_speed", {5'b0, speed}, 8'd0);
        check("rst_target", {5'b0, target}, 8'd0);
        check("rst_busy", {7'b0, busy}, 8'd0);
        @(negedge clock);
        reset_n = 1'b1;
        idle(3);

        // Clean held up press: edge k is the first step
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (i == 6)  check("up_target_before", {5'b0, target}, 8'd0);
            if (i == 7)  check("up_target_after", {5'b0, target}, 8'd1);
            if (i == 7)  check("up_busy_start", {7'b0, busy}, 8'd1);
            if (i == 14) check("up_speed_before", {5'b0, speed}, 8'd0);
            if (i == 14) check("up_busy_end", {7'b0, busy}, 8'd1);
            if (i == 15) check("up_speed_after", {5'b0, speed}, 8'd1);
            if (i == 15) check("up_busy_clear", {7'b0, busy}, 8'd0);
        end
        check("up_held_once", {5'b0, target}, 8'd1);
        idle(10);

        // Bouncing up button, then a steady hold
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("bounce_no_change", {5'b0, target}, 8'd1);
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (i == 6) check("bounce_target_before", {5'b0, target}, 8'd1);
            if (i == 7) check("bounce_target_after", {5'b0, target}, 8'd2);
        end
        idle(8);
        wait_idle(40);

        // Saturation up and down
        press_btn(1'b0, 1'b0, 1'b1);
        check("stop_target", {5'b0, target}, 8'd0);
        check("stop_speed", {5'b0, speed}, 8'd0);
        for (int i = 1; i <= 8; i++) begin
            press_btn(1'b1, 1'b0, 1'b0);
            check("sat_up", {5'b0, target}, (i < 7) ? 8'(i) : 8'd7);
        end
        wait_idle(100);
        check("sat_up_speed", {5'b0, speed}, 8'd7);
        for (int i = 1; i <= 8; i++) begin
            press_btn(1'b0, 1'b1, 1'b0);
            check("sat_down", {5'b0, target}, (7 - i > 0) ? 8'(7 - i) : 8'd0);
        end
        wait_idle(100);
        check("sat_down_speed", {5'b0, speed}, 8'd0);

        // Stop override while ramping toward 7
        for (int i = 0; i < 7; i++) press_btn(1'b1, 1'b0, 1'b0);
        check("pre_stop_target", {5'b0, target}, 8'd7);
        prev_speed = speed;
        n = 0;
        while (target != 3'd0 && n < 30) begin
            prev_speed = speed;
            step(1'b0, 1'b0, 1'b1);
            n++;
        end
        check("stop_prev_speed_nonzero", {7'b0, (prev_speed != 3'd0)}, 8'd1);
        check("stop_target_zero", {5'b0, target}, 8'd0);
        check("stop_speed_zero", {5'b0, speed}, 8'd0);
        check("stop_busy_zero", {7'b0, busy}, 8'd0);
        idle(8);
        press_btn(1'b1, 1'b0, 1'b0);
        check("updown_pre", {5'b0, target}, 8'd1);
        press_btn(1'b1, 1'b1, 1'b0);
        check("updown_same", {5'b0, target}, 8'd1);
        wait_idle(40);

        // Reversal mid-ramp
        press_btn(1'b1, 1'b0, 1'b0);
        wait_idle(40);
        check("rev_start", {5'b0, speed}, 8'd2);
        for (int i = 0; i < 3; i++) press_btn(1'b1, 1'b0, 1'b0);
        press_btn(1'b0, 1'b1, 1'b0);
        check("rev_target", {5'b0, target}, 8'd4);
        wait_idle(60);
        check("rev_speed", {5'b0, speed}, 8'd4);

        // Random button activity
        for (int seg = 0; seg < 60; seg++) begin
            bit u, d, st;
            int len;
            u   = 1'($urandom_range(0, 1));
            d   = 1'($urandom_range(0, 1));
            st  = ($urandom_range(0, 11) == 0);
            len = $urandom_range(1, 10);
            repeat (len) step(u, d, st);
        end
        idle(12);
        wait_idle(100);

        // Asynchronous reset in the middle of a ramp
        press_btn(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) press_btn(1'b1, 1'b0, 1'b0);
        check("mid_ramp_busy", {7'b0, busy}, 8'd1);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_speed", {5'b0, speed}, 8'd0);
        check("async_rst_target", {5'b0, target}, 8'd0);
        check("async_rst_busy", {7'b0, busy}, 8'd0);
        @(negedge clock);
        reset_n = 1'b1;
        idle(6);
        check("post_rst_target", {5'b0, target}, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
